// File: rtl/medidor_faixa_uc.sv
// Control unit for the HC-SR04 range game: paces measurements every interval,
// streams the "XYZ#" report per measurement and the final "AAA#" report.
module medidor_faixa_uc #(
    parameter int TIMEOUT_ESPERA = 3_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       pronto_medida,
    input  logic       fim_time,
    input  logic       fim_3sec,
    input  logic       pronto_tx,
    input  logic       is_ultimo_char,
    input  logic       is_ultimo_char_a,
    output logic       zera,
    output logic       zera_time,
    output logic       conta_time,
    output logic       mensurar,
    output logic       partida_tx,
    output logic       conta_prox_char,
    output logic       zera_char,
    output logic       conta_prox_char_a,
    output logic       zera_char_a,
    output logic       registra_acertou,
    output logic       pronto,
    output logic [3:0] db_estado
);

    localparam int CNT_W = (TIMEOUT_ESPERA > 1) ? $clog2(TIMEOUT_ESPERA) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_ESPERA - 1);

    typedef enum logic [3:0] {
        INICIAL          = 4'h0,
        PREPARACAO       = 4'h1,
        ESPERA_INTERVALO = 4'h2,
        MEDE             = 4'h3,
        AGUARDA_MEDIDA   = 4'h4,
        AVALIA           = 4'h5,
        TRANSMITE        = 4'h6,
        ESPERA_TX        = 4'h7,
        PROX_CHAR        = 4'h8,
        FIM_TX           = 4'h9,
        REGISTRA         = 4'hA,
        TRANSMITE_A      = 4'hB,
        ESPERA_TX_A      = 4'hC,
        PROX_CHAR_A      = 4'hD,
        FINAL            = 4'hE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= INICIAL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Timeout counter: cleared on every trigger, held at its top value rather than wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == MEDE) begin
            cnt_d = '0;
        end else if (state_q == AGUARDA_MEDIDA && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            INICIAL:          if (iniciar) state_d = PREPARACAO;
            PREPARACAO:       state_d = ESPERA_INTERVALO;
            ESPERA_INTERVALO: if (fim_time) state_d = MEDE;
            MEDE:             state_d = AGUARDA_MEDIDA;
            AGUARDA_MEDIDA: begin
                // A completed measurement beats a simultaneous timeout.
                if (pronto_medida)         state_d = AVALIA;
                else if (cnt_q == CNT_MAX) state_d = MEDE;
            end
            AVALIA:           state_d = fim_3sec ? REGISTRA : TRANSMITE;
            TRANSMITE:        state_d = ESPERA_TX;
            ESPERA_TX: begin
                if (pronto_tx) state_d = is_ultimo_char ? FIM_TX : PROX_CHAR;
            end
            PROX_CHAR:        state_d = TRANSMITE;
            FIM_TX:           state_d = ESPERA_INTERVALO;
            REGISTRA:         state_d = TRANSMITE_A;
            TRANSMITE_A:      state_d = ESPERA_TX_A;
            ESPERA_TX_A: begin
                if (pronto_tx) state_d = is_ultimo_char_a ? FINAL : PROX_CHAR_A;
            end
            PROX_CHAR_A:      state_d = TRANSMITE_A;
            FINAL:            if (iniciar) state_d = PREPARACAO;
            default:          state_d = INICIAL;
        endcase
    end

    always_comb begin
        zera              = 1'b0;
        zera_time         = 1'b0;
        conta_time        = 1'b0;
        mensurar          = 1'b0;
        partida_tx        = 1'b0;
        conta_prox_char   = 1'b0;
        zera_char         = 1'b0;
        conta_prox_char_a = 1'b0;
        zera_char_a       = 1'b0;
        registra_acertou  = 1'b0;
        pronto            = 1'b0;
        case (state_q)
            PREPARACAO: begin
                zera        = 1'b1;
                zera_time   = 1'b1;
                zera_char   = 1'b1;
                zera_char_a = 1'b1;
            end
            ESPERA_INTERVALO: conta_time = 1'b1;
            MEDE:             mensurar = 1'b1;
            TRANSMITE:        partida_tx = 1'b1;
            PROX_CHAR:        conta_prox_char = 1'b1;
            FIM_TX: begin
                zera_char = 1'b1;
                zera_time = 1'b1;
            end
            REGISTRA: begin
                registra_acertou = 1'b1;
                zera_char_a      = 1'b1;
            end
            TRANSMITE_A:      partida_tx = 1'b1;
            PROX_CHAR_A:      conta_prox_char_a = 1'b1;
            FINAL:            pronto = 1'b1;
            default: ;
        endcase
    end

    assign db_estado = state_q;

endmodule

// File: tb/tb_medidor_faixa_uc.sv
// Scoreboard bench for medidor_faixa_uc: expected state visits (outputs, dwell) are
// queued by the stimulus and checked by an independent monitor on the falling edge.
module tb_medidor_faixa_uc;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic iniciar = 1'b0, pronto_medida = 1'b0, fim_time = 1'b0, fim_3sec = 1'b0;
    logic pronto_tx = 1'b0, is_ultimo_char = 1'b0, is_ultimo_char_a = 1'b0;
    logic zera, zera_time, conta_time, mensurar, partida_tx, conta_prox_char;
    logic zera_char, conta_prox_char_a, zera_char_a, registra_acertou, pronto;
    logic [3:0] db_estado;

    medidor_faixa_uc #(.TIMEOUT_ESPERA(8)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .pronto_medida(pronto_medida),
        .fim_time(fim_time), .fim_3sec(fim_3sec), .pronto_tx(pronto_tx),
        .is_ultimo_char(is_ultimo_char), .is_ultimo_char_a(is_ultimo_char_a),
        .zera(zera), .zera_time(zera_time), .conta_time(conta_time), .mensurar(mensurar),
        .partida_tx(partida_tx), .conta_prox_char(conta_prox_char), .zera_char(zera_char),
        .conta_prox_char_a(conta_prox_char_a), .zera_char_a(zera_char_a),
        .registra_acertou(registra_acertou), .pronto(pronto), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    // {zera, zera_time, conta_time, mensurar, partida_tx, conta_prox_char,
    //  zera_char, conta_prox_char_a, zera_char_a, registra_acertou, pronto}
    logic [10:0] outs;
    assign outs = {zera, zera_time, conta_time, mensurar, partida_tx, conta_prox_char,
                   zera_char, conta_prox_char_a, zera_char_a, registra_acertou, pronto};

    localparam logic [3:0] S_INI = 4'h0, S_PREP = 4'h1, S_ESPI = 4'h2, S_MEDE = 4'h3,
                           S_AGU = 4'h4, S_AVAL = 4'h5, S_TX = 4'h6, S_ETX = 4'h7,
                           S_PROX = 4'h8, S_FIMTX = 4'h9, S_REG = 4'hA, S_TXA = 4'hB,
                           S_ETXA = 4'hC, S_PROXA = 4'hD, S_FINAL = 4'hE;

    localparam logic [10:0] O_NONE  = 11'b00000000000;
    localparam logic [10:0] O_PREP  = 11'b11000010100;
    localparam logic [10:0] O_ESPI  = 11'b00100000000;
    localparam logic [10:0] O_MEDE  = 11'b00010000000;
    localparam logic [10:0] O_TX    = 11'b00001000000;
    localparam logic [10:0] O_PROX  = 11'b00000100000;
    localparam logic [10:0] O_FIMTX = 11'b01000010000;
    localparam logic [10:0] O_REG   = 11'b00000000110;
    localparam logic [10:0] O_PROXA = 11'b00000001000;
    localparam logic [10:0] O_FINAL = 11'b00000000001;

    typedef struct {
        logic [3:0]  st;
        logic [10:0] outs;
        int          dwell;   // cycles expected in this state, 0 = paced by the bench
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic mon_en = 1'b0;

    function automatic void push(input logic [3:0] st, input logic [10:0] o, input int dw);
        exp_t e;
        e.st = st; e.outs = o; e.dwell = dw;
        q.push_back(e);
    endfunction

    // Monitor: pops one expectation per observed state change, checks dwell and outputs.
    initial begin : monitor
        exp_t       cur;
        logic       have_cur;
        logic [4:0] prev;
        int         cnt;
        have_cur = 1'b0;
        prev = 5'h1F;
        cnt = 0;
        forever begin
            @(negedge clock);
            if (mon_en) begin
                if ({1'b0, db_estado} != prev) begin
                    if (have_cur && cur.dwell != 0) begin
                        vectors++;
                        if (cnt != cur.dwell) begin
                            miscompares++;
                            $display("FAIL dwell state %0h: %0d cycles, required %0d", cur.st, cnt, cur.dwell);
                        end
                    end
                    if (q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_transition: state %0h, required no change", db_estado);
                        have_cur = 1'b0;
                    end else begin
                        cur = q.pop_front();
                        have_cur = 1'b1;
                        vectors++;
                        if (db_estado !== cur.st) begin
                            miscompares++;
                            $display("FAIL next_state: state %0h, required %0h", db_estado, cur.st);
                        end else begin
                            $display("enter state %0h outs %b", db_estado, outs);
                        end
                    end
                    prev = {1'b0, db_estado};
                    cnt = 1;
                end else begin
                    cnt++;
                end
                if (have_cur) begin
                    vectors++;
                    if (outs !== cur.outs) begin
                        miscompares++;
                        $display("FAIL outputs state %0h: %b, required %b", db_estado, outs, cur.outs);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_state(input logic [3:0] s);
        int k = 0;
        while (db_estado !== s && k < 200) begin
            tick(1);
            k++;
        end
        if (db_estado !== s) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_state: state %0h, required %0h", db_estado, s);
        end
    endtask

    task automatic send_char(input logic [3:0] wait_st, input int idx, input logic alt);
        wait_state(wait_st);
        tick(2);
        if (alt) is_ultimo_char_a = (idx == 3);
        else     is_ultimo_char   = (idx == 3);
        pronto_tx = 1'b1;
        tick(1);
        pronto_tx = 1'b0;
        is_ultimo_char = 1'b0;
        is_ultimo_char_a = 1'b0;
    endtask

    initial begin : stimulus
        // Reset, then spurious inputs in inicial must not move the FSM
        push(S_INI, O_NONE, 0);
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        mon_en = 1'b1;
        tick(1);
        pronto_tx = 1'b1; fim_time = 1'b1; pronto_medida = 1'b1;
        tick(2);
        pronto_tx = 1'b0; fim_time = 1'b0; pronto_medida = 1'b0;
        tick(2);

        // Start: preparacao for one cycle, then count the interval
        push(S_PREP, O_PREP, 1);
        push(S_ESPI, O_ESPI, 0);
        iniciar = 1'b1;
        tick(1);
        iniciar = 1'b0;
        wait_state(S_ESPI);
        tick(3);
        iniciar = 1'b1;          // ignored in espera_intervalo
        tick(1);
        iniciar = 1'b0;
        tick(2);

        // Measurement returns quickly; iniciar/fim_time in aguarda are ignored
        push(S_MEDE, O_MEDE, 1);
        push(S_AGU, O_NONE, 2);
        push(S_AVAL, O_NONE, 1);
        for (int i = 0; i < 4; i++) begin
            push(S_TX, O_TX, 1);
            push(S_ETX, O_NONE, 0);
            if (i < 3) push(S_PROX, O_PROX, 1);
        end
        push(S_FIMTX, O_FIMTX, 1);
        push(S_ESPI, O_ESPI, 0);
        fim_time = 1'b1;
        tick(1);
        fim_time = 1'b0;
        wait_state(S_AGU);
        iniciar = 1'b1; fim_time = 1'b1;
        tick(1);
        iniciar = 1'b0; fim_time = 1'b0;
        pronto_medida = 1'b1; fim_3sec = 1'b0;
        tick(1);
        pronto_medida = 1'b0;
        for (int i = 0; i < 4; i++) send_char(S_ETX, i, 1'b0);
        wait_state(S_ESPI);
        pronto_tx = 1'b1;        // ignored in espera_intervalo
        tick(1);
        pronto_tx = 1'b0;
        tick(2);

        // Two echo timeouts (9-cycle retrigger), then pronto_medida on the timeout cycle
        push(S_MEDE, O_MEDE, 1);
        push(S_AGU, O_NONE, 8);
        push(S_MEDE, O_MEDE, 1);
        push(S_AGU, O_NONE, 8);
        push(S_MEDE, O_MEDE, 1);
        push(S_AGU, O_NONE, 8);
        push(S_AVAL, O_NONE, 1);
        push(S_REG, O_REG, 1);
        for (int i = 0; i < 4; i++) begin
            push(S_TXA, O_TX, 1);
            push(S_ETXA, O_NONE, 0);
            if (i < 3) push(S_PROXA, O_PROXA, 1);
        end
        push(S_FINAL, O_FINAL, 0);
        fim_time = 1'b1;
        tick(1);
        fim_time = 1'b0;
        wait_state(S_AGU);
        tick(9);
        tick(9);
        tick(7);
        pronto_medida = 1'b1; fim_3sec = 1'b1;
        tick(1);
        pronto_medida = 1'b0;
        for (int i = 0; i < 4; i++) send_char(S_ETXA, i, 1'b1);
        fim_3sec = 1'b0;
        wait_state(S_FINAL);
        tick(4);

        // Restart from final, then reset in the middle of a transmission
        push(S_PREP, O_PREP, 1);
        push(S_ESPI, O_ESPI, 0);
        iniciar = 1'b1;
        tick(1);
        iniciar = 1'b0;
        wait_state(S_ESPI);
        tick(2);
        push(S_MEDE, O_MEDE, 1);
        push(S_AGU, O_NONE, 1);
        push(S_AVAL, O_NONE, 1);
        push(S_TX, O_TX, 1);
        push(S_ETX, O_NONE, 0);
        push(S_INI, O_NONE, 0);
        fim_time = 1'b1;
        tick(1);
        fim_time = 1'b0;
        wait_state(S_AGU);
        pronto_medida = 1'b1;
        tick(1);
        pronto_medida = 1'b0;
        wait_state(S_ETX);
        tick(1);
        reset = 1'b1; pronto_tx = 1'b1;
        tick(1);
        reset = 1'b0;
        fim_time = 1'b1;         // spurious in inicial
        tick(2);
        pronto_tx = 1'b0; fim_time = 1'b0;
        tick(4);

        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL pending_expectations: %0d left, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
